if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the number of {PC, instruction} entries; legal values are powers of two, at least 2.
REQ-002 The module SHALL have parameter CW, default 3, giving the count width; CW = log2(DEPTH)+1.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  branch taken; discards all queued entries.
REQ-006 push_valid  input  1  fetch stage offers an entry this cycle.
REQ-007 push_pc  input  32  PC+4 value of the offered entry.
REQ-008 push_instruction  input  32  instruction word of the offered entry.
REQ-009 pop  input  1  decode stage consumes the head entry this cycle (decode not frozen).
REQ-010 full  output  1  count == DEPTH; drives the fetch-stage freeze.
REQ-011 out_valid  output  1  head entry present (count != 0).
REQ-012 out_pc  output  32  PC of the head entry.
REQ-013 out_instruction  output  32  instruction of the head entry.
REQ-014 count  output  CW  number of valid entries, 0..DEPTH.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries, 64 bits each, with a write pointer, a read pointer and a count register.
REQ-016 A push SHALL be accepted when push_valid=1, full=0 and flush=0; the entry is written at the write pointer, which then increments modulo DEPTH.
REQ-017 A pop SHALL be accepted when pop=1, out_valid=1 and flush=0; the read pointer then increments modulo DEPTH.
REQ-018 pop while out_valid=0 SHALL be ignored, with no state change.
REQ-019 push_valid while full=1 SHALL be ignored; the entry is dropped, and fetch is responsible for holding via freeze.
REQ-020 A simultaneous accepted push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 When full=1, a push in the same cycle as a pop SHALL still be rejected, because full is evaluated from the pre-edge count.
REQ-022 Output SHALL be first-word-fall-through: out_pc and out_instruction are driven combinationally from the entry at the read pointer.
REQ-023 Latency SHALL be one cycle: an entry pushed into an empty queue appears with out_valid=1 on the cycle after the push edge.
REQ-024 When out_valid=0, out_pc and out_instruction SHALL be driven to 32'h0, never stale data.
REQ-025 full and out_valid SHALL be derived combinationally from the count register only, never from push or pop inputs.
REQ-026 flush=1 SHALL, at the next edge, set count, write pointer and read pointer to 0 and discard any same-cycle push and pop; flush takes priority over both.
REQ-027 The buffer memory itself SHALL NOT require reset or flush clearing; validity is tracked by count alone.
REQ-028 Entries SHALL leave the queue in push order, without duplication or loss, across pointer wrap-around.

Reset
REQ-029 While rst=1, count, the write pointer and the read pointer SHALL be 0 immediately, independent of clk.
REQ-030 While rst=1, full=0, out_valid=0, out_pc=0 and out_instruction=0.
REQ-031 Reset asserted mid-operation SHALL discard all entries; after rst falls, the first accepted push is the next head.
REQ-032 Reset SHALL take priority over flush, push and pop.

Verification
REQ-033 Reset then single push: rst pulse; push {pc=4, instr=E3A00001} -> next cycle out_valid=1, out_pc=4, out_instruction=E3A00001, count=1.
REQ-034 Fill and block: push pc=4,8,12,16 with pop=0 -> full=1, count=4; a fifth push of pc=20 is dropped; then 4 pops return 4,8,12,16, and count=0, out_pc=0.
REQ-035 Wrap-around: steady push and pop in the same cycle for 10 cycles with pc=4..40 -> count constant, pops return pc in order across pointer wrap.
REQ-036 Flush priority: count=3; assert flush together with push pc=100 and pop -> next cycle count=0, out_valid=0; pc=100 is never output.
REQ-037 Full with simultaneous pop: count=4; push pc=200 and pop together -> count=3, head advances, pc=200 is absent from the following pops.
REQ-038 Asynchronous reset mid-stream: count=2; raise rst between clock edges -> out_valid=0 and count=0 before the next edge; after release, push pc=300 -> head pc=300.

Source files
------------

// File: rtl/if_id_queue.sv
// IF/ID pipeline queue: circular buffer of {pc, instruction} entries between fetch and decode.
// The head entry falls through combinationally; flush and reset drop all queued entries.
module if_id_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push_valid,
    input  logic [31:0]   push_pc,
    input  logic [31:0]   push_instruction,
    input  logic          pop,
    output logic          full,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instruction,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [63:0]   mem [DEPTH];
    logic [63:0]   head;
    logic          push_ok;
    logic          pop_ok;

    // Status comes from the registered count only, so a full queue rejects a push even alongside a pop
    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push_ok   = push_valid & ~full & ~flush;
    assign pop_ok    = pop & out_valid & ~flush;

    // Gate the head to zero when empty so stale entries never reach decode
    assign head            = mem[rd_ptr];
    assign out_pc          = out_valid ? head[63:32] : 32'h0;
    assign out_instruction = out_valid ? head[31:0]  : 32'h0;

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {push_pc, push_instruction};
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: expected entries are queued on accepted pushes and
// compared against the fall-through head when the bench pops.
module tb_if_id_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          push_valid;
    logic [31:0]   push_pc;
    logic [31:0]   push_instruction;
    logic          pop;
    logic          full;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instruction;
    logic [CW-1:0] count;

    logic [63:0] sb [$];
    int total = 0;
    int bad   = 0;

    if_id_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_valid(push_valid), .push_pc(push_pc), .push_instruction(push_instruction),
        .pop(pop), .full(full), .out_valid(out_valid),
        .out_pc(out_pc), .out_instruction(out_instruction), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle, update the reference queue and capture the head seen before the edge
    task automatic step(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic pp, input logic fl,
                        output logic popped, output logic [63:0] got, output logic [63:0] exp);
        int pre;
        push_valid = pv; push_pc = pc; push_instruction = ins; pop = pp; flush = fl;
        pre    = sb.size();
        got    = {out_pc, out_instruction};
        exp    = 64'h0;
        popped = pp && !fl && (pre > 0);
        if (fl) begin
            sb.delete();
        end else begin
            if (popped) exp = sb.pop_front();
            if (pv && pre < int'(DEPTH)) sb.push_back({pc, ins});
        end
        @(posedge clk);
        #1;
        push_valid = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; push_valid = 1'b0; pop = 1'b0;
        push_pc = 32'h0; push_instruction = 32'h0;
        #1 rst = 1'b1;
        #1;
        total++;
        if ({full, out_valid, count} !== {1'b0, 1'b0, CW'(0)}) begin
            bad++; $display("FAIL reset_status: full=%b out_valid=%b count=%0d, want 0 0 0", full, out_valid, count);
        end
        total++;
        if ({out_pc, out_instruction} !== 64'h0) begin
            bad++; $display("FAIL reset_data: got %h, want 0", {out_pc, out_instruction});
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_single_push();
        logic p; logic [63:0] g, e;
        step(1'b1, 32'd4, 32'hE3A00001, 1'b0, 1'b0, p, g, e);
        total++;
        if ({out_valid, out_pc, out_instruction, count} !== {1'b1, 32'd4, 32'hE3A00001, CW'(1)}) begin
            bad++; $display("FAIL single_push: valid=%b pc=%h ins=%h count=%0d, want 1 4 e3a00001 1",
                            out_valid, out_pc, out_instruction, count);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, g, e);
        total++;
        if (!p || g !== e) begin
            bad++; $display("FAIL single_pop: got %h, want %h (popped=%b)", g, e, p);
        end
    endtask

    task automatic test_fill_block();
        logic p; logic [63:0] g, e;
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(4 * i), 32'hA000_0000 | 32'(i), 1'b0, 1'b0, p, g, e);
        total++;
        if ({full, count} !== {1'b1, CW'(4)}) begin
            bad++; $display("FAIL fill: full=%b count=%0d, want 1 4", full, count);
        end
        step(1'b1, 32'd20, 32'hA000_0005, 1'b0, 1'b0, p, g, e);
        total++;
        if ({full, count, out_pc} !== {1'b1, CW'(4), 32'd4}) begin
            bad++; $display("FAIL push_when_full: full=%b count=%0d head=%0d, want 1 4 4", full, count, out_pc);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, g, e);
            total++;
            if (!p || g !== e) begin
                bad++; $display("FAIL drain_%0d: got %h, want %h", i, g, e);
            end
        end
        total++;
        if ({count, out_valid, out_pc, out_instruction} !== {CW'(0), 1'b0, 64'h0}) begin
            bad++; $display("FAIL drained_empty: count=%0d valid=%b data=%h, want 0 0 0",
                            count, out_valid, {out_pc, out_instruction});
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, g, e);
        total++;
        if ({count, out_valid} !== {CW'(0), 1'b0}) begin
            bad++; $display("FAIL pop_empty: count=%0d valid=%b, want 0 0", count, out_valid);
        end
    endtask

    task automatic test_wrap();
        logic p; logic [63:0] g, e;
        step(1'b1, 32'd4, 32'hB000_0004, 1'b0, 1'b0, p, g, e);
        step(1'b1, 32'd8, 32'hB000_0008, 1'b0, 1'b0, p, g, e);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'(12 + 4 * i), 32'hB000_0000 | 32'(12 + 4 * i), 1'b1, 1'b0, p, g, e);
            total++;
            if (!p || g !== e || count !== CW'(2)) begin
                bad++; $display("FAIL wrap_%0d: got %h count=%0d, want %h count=2", i, g, count, e);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, g, e);
            total++;
            if (!p || g !== e) begin
                bad++; $display("FAIL wrap_drain_%0d: got %h, want %h", i, g, e);
            end
        end
    endtask

    task automatic test_flush();
        logic p; logic [63:0] g, e;
        for (int i = 0; i < 3; i++) step(1'b1, 32'(50 + 4 * i), 32'hC000_0000 | 32'(i), 1'b0, 1'b0, p, g, e);
        total++;
        if (count !== CW'(3)) begin
            bad++; $display("FAIL flush_pre: count=%0d, want 3", count);
        end
        step(1'b1, 32'd100, 32'hC000_0100, 1'b1, 1'b1, p, g, e);
        total++;
        if ({count, out_valid, out_pc} !== {CW'(0), 1'b0, 32'h0}) begin
            bad++; $display("FAIL flush: count=%0d valid=%b pc=%0d, want 0 0 0", count, out_valid, out_pc);
        end
        step(1'b1, 32'd104, 32'hC000_0104, 1'b0, 1'b0, p, g, e);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, g, e);
        total++;
        if (!p || g !== e || g[63:32] !== 32'd104) begin
            bad++; $display("FAIL flush_after: got %h, want %h", g, e);
        end
    endtask

    task automatic test_full_pop();
        logic p; logic [63:0] g, e;
        for (int i = 0; i < 4; i++) step(1'b1, 32'(150 + 4 * i), 32'hD000_0000 | 32'(i), 1'b0, 1'b0, p, g, e);
        step(1'b1, 32'd200, 32'hD000_0200, 1'b1, 1'b0, p, g, e);
        total++;
        if (!p || g !== e || count !== CW'(3) || out_pc !== 32'd154) begin
            bad++; $display("FAIL full_pop: got %h count=%0d head=%0d, want %h 3 154", g, count, out_pc, e);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, g, e);
            total++;
            if (!p || g !== e || g[63:32] == 32'd200) begin
                bad++; $display("FAIL full_pop_drain_%0d: got %h, want %h", i, g, e);
            end
        end
        total++;
        if (count !== CW'(0)) begin
            bad++; $display("FAIL full_pop_empty: count=%0d, want 0", count);
        end
    endtask

    task automatic test_async_reset();
        logic p; logic [63:0] g, e;
        step(1'b1, 32'd250, 32'hE000_0250, 1'b0, 1'b0, p, g, e);
        step(1'b1, 32'd254, 32'hE000_0254, 1'b0, 1'b0, p, g, e);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        total++;
        if ({out_valid, count, full, out_pc} !== {1'b0, CW'(0), 1'b0, 32'h0}) begin
            bad++; $display("FAIL async_reset: valid=%b count=%0d full=%b pc=%0d, want 0 0 0 0",
                            out_valid, count, full, out_pc);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        step(1'b1, 32'd300, 32'hE000_0300, 1'b0, 1'b0, p, g, e);
        total++;
        if ({out_valid, out_pc, count} !== {1'b1, 32'd300, CW'(1)}) begin
            bad++; $display("FAIL after_reset: valid=%b pc=%0d count=%0d, want 1 300 1", out_valid, out_pc, count);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, g, e);
    endtask

    task automatic test_back_to_back();
        logic p; logic [63:0] g, e;
        logic [63:0] hd;
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, 32'h1000 + 32'(4 * i), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, p, g, e);
            if (p) begin
                total++;
                if (g !== e) begin
                    bad++; $display("FAIL random_pop_%0d: got %h, want %h", i, g, e);
                end
            end
            hd = (sb.size() > 0) ? sb[0] : 64'h0;
            total++;
            if (count !== CW'(sb.size()) || out_valid !== (sb.size() > 0) ||
                full !== (sb.size() == DEPTH) || {out_pc, out_instruction} !== hd) begin
                bad++; $display("FAIL random_state_%0d: count=%0d valid=%b full=%b head=%h, want count=%0d head=%h",
                                i, count, out_valid, full, {out_pc, out_instruction}, sb.size(), hd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_block();
        test_wrap();
        test_flush();
        test_full_pop();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
